// File: rtl/regfile_mp_sb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_mp_sb_if : read / issue / write-back bundle for regfile_mp_sb
// Rev 1.0
// ---------------------------------------------------------------------------
interface regfile_mp_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRP-1:0]      rs_re;
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP*XLEN-1:0] rs_data;
  logic [NRP-1:0]      rs_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                iss_ready;
  logic [NWP-1:0]      wb_we;
  logic [NWP*AW-1:0]   wb_addr;
  logic [NWP*XLEN-1:0] wb_data;
  logic                flush;

  modport master (
    output rs_re, rs_addr, iss_valid, iss_addr, wb_we, wb_addr, wb_data, flush,
    input  rs_data, rs_busy, iss_ready
  );

  modport slave (
    input  rs_re, rs_addr, iss_valid, iss_addr, wb_we, wb_addr, wb_data, flush,
    output rs_data, rs_busy, iss_ready
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_mp_sb : multi-port register file, write-back forwarding, scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRP     = 2,
  parameter int NWP     = 2,
  parameter int CNTW    = 2,
  parameter int RD_REG  = 0,
  parameter int ZERO_R0 = 1
) (
  input  logic            clk,
  input  logic            rst,
  regfile_mp_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int HW = $clog2(NWP + 1);
  localparam int CW = ((CNTW > HW) ? CNTW : HW) + 1;
  localparam logic [CNTW-1:0] C_CNT_MAX = {CNTW{1'b1}};

  logic [XLEN-1:0] r_mem [NREG];
  logic [CNTW-1:0] r_cnt [NREG];

  logic [XLEN-1:0] w_rd_data [NRP];
  logic [HW-1:0]   w_rd_hits [NRP];
  logic [NRP-1:0]  w_rd_busy;
  logic [HW-1:0]   w_sb_hits [NREG];
  logic [CW-1:0]   w_sb_dec  [NREG];
  logic [NREG-1:0] w_sb_inc;
  logic [CNTW-1:0] w_cnt_nxt [NREG];
  logic            w_iss_ready;

  // Ready looks only at the current count, so a retiring write cannot lift a stall.
  assign w_iss_ready   = !rst && (r_cnt[bus.iss_addr] != C_CNT_MAX);
  assign bus.iss_ready = w_iss_ready;

  always_comb begin
    w_rd_data = '{default: '0};
    w_rd_hits = '{default: '0};
    w_rd_busy = '0;
    for (int i = 0; i < NRP; i++) begin
      w_rd_data[i] = r_mem[bus.rs_addr[i*AW +: AW]];
      // Ascending scan: the highest-numbered matching write port overrides.
      for (int k = 0; k < NWP; k++) begin
        if (bus.wb_we[k] && (bus.wb_addr[k*AW +: AW] == bus.rs_addr[i*AW +: AW])) begin
          w_rd_data[i] = bus.wb_data[k*XLEN +: XLEN];
          w_rd_hits[i] = w_rd_hits[i] + HW'(1);
        end
      end
      if (!bus.rs_re[i] || ((ZERO_R0 != 0) && (bus.rs_addr[i*AW +: AW] == '0))) begin
        w_rd_data[i] = '0;
      end
      w_rd_busy[i] = bus.rs_re[i] &&
                     (CW'(r_cnt[bus.rs_addr[i*AW +: AW]]) > CW'(w_rd_hits[i]));
    end
  end

  always_comb begin
    w_sb_hits = '{default: '0};
    w_sb_dec  = '{default: '0};
    w_sb_inc  = '0;
    w_cnt_nxt = '{default: '0};
    for (int r = 0; r < NREG; r++) begin
      for (int k = 0; k < NWP; k++) begin
        if (bus.wb_we[k] && (bus.wb_addr[k*AW +: AW] == AW'(r))) begin
          w_sb_hits[r] = w_sb_hits[r] + HW'(1);
        end
      end
      // Surplus writes beyond the pending count are plain writes, not retirements.
      w_sb_dec[r] = (CW'(w_sb_hits[r]) > CW'(r_cnt[r])) ? CW'(r_cnt[r]) : CW'(w_sb_hits[r]);
      w_sb_inc[r] = bus.iss_valid && w_iss_ready && (bus.iss_addr == AW'(r));
      w_cnt_nxt[r] = CNTW'(CW'(r_cnt[r]) + CW'(w_sb_inc[r]) - w_sb_dec[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_mem[r] <= '0;
        r_cnt[r] <= '0;
      end
    end else begin
      for (int k = 0; k < NWP; k++) begin
        if (bus.wb_we[k] && !((ZERO_R0 != 0) && (bus.wb_addr[k*AW +: AW] == '0))) begin
          r_mem[bus.wb_addr[k*AW +: AW]] <= bus.wb_data[k*XLEN +: XLEN];
        end
      end
      for (int r = 0; r < NREG; r++) begin
        if (bus.flush || ((ZERO_R0 != 0) && (r == 0))) begin
          r_cnt[r] <= '0;
        end else begin
          r_cnt[r] <= w_cnt_nxt[r];
        end
      end
    end
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [XLEN-1:0] r_rd_data [NRP];
    logic [NRP-1:0]  r_rd_busy;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_data <= '{default: '0};
        r_rd_busy <= '0;
      end else begin
        r_rd_data <= w_rd_data;
        r_rd_busy <= w_rd_busy;
      end
    end

    always_comb begin
      bus.rs_data = '0;
      for (int i = 0; i < NRP; i++) begin
        bus.rs_data[i*XLEN +: XLEN] = rst ? '0 : r_rd_data[i];
      end
      bus.rs_busy = rst ? '0 : r_rd_busy;
    end
  end else begin : g_rd_comb
    always_comb begin
      bus.rs_data = '0;
      for (int i = 0; i < NRP; i++) begin
        bus.rs_data[i*XLEN +: XLEN] = rst ? '0 : w_rd_data[i];
      end
      bus.rs_busy = rst ? '0 : w_rd_busy;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_regfile_mp_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_mp_sb : directed vector table plus randomized reference-model run
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_mp_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int CNTW = 2;
  localparam int AW   = 5;

  typedef struct {
    logic            rst;
    logic [1:0]      re;
    logic [AW-1:0]   ra0, ra1;
    logic            iv;
    logic [AW-1:0]   ia;
    logic [1:0]      we;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic            fl;
    logic [XLEN-1:0] ed0, ed1;
    logic [1:0]      eb;
    logic            er;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [XLEN-1:0] m_mem [NREG];
  int              m_cnt [NREG];
  vec_t            tbl [$];

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) bus ();

  regfile_mp_sb #(
    .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP),
    .CNTW(CNTW), .RD_REG(0), .ZERO_R0(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic vec_t mk(logic r, logic [1:0] re, int ra0, int ra1, logic iv, int ia,
                              logic [1:0] we, int wa0, logic [31:0] wd0, int wa1,
                              logic [31:0] wd1, logic fl, logic [31:0] ed0,
                              logic [31:0] ed1, logic [1:0] eb, logic er);
    vec_t v;
    v.rst = r;  v.re = re;  v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
    v.iv = iv;  v.ia = AW'(ia); v.we = we;
    v.wa0 = AW'(wa0); v.wd0 = wd0; v.wa1 = AW'(wa1); v.wd1 = wd1; v.fl = fl;
    v.ed0 = ed0; v.ed1 = ed1; v.eb = eb; v.er = er;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst           = v.rst;
    bus.rs_re     = v.re;
    bus.rs_addr   = {v.ra1, v.ra0};
    bus.iss_valid = v.iv;
    bus.iss_addr  = v.ia;
    bus.wb_we     = v.we;
    bus.wb_addr   = {v.wa1, v.wa0};
    bus.wb_data   = {v.wd1, v.wd0};
    bus.flush     = v.fl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_row(input vec_t v, input string tag);
    chk({tag, " rs_data0"}, bus.rs_data[XLEN-1:0], v.ed0);
    chk({tag, " rs_data1"}, bus.rs_data[2*XLEN-1:XLEN], v.ed1);
    chk({tag, " rs_busy"}, {30'd0, bus.rs_busy}, {30'd0, v.eb});
    chk({tag, " iss_ready"}, {31'd0, bus.iss_ready}, {31'd0, v.er});
  endtask

  // Reference model: architectural registers plus a plain pending-write count each.
  function automatic vec_t model_expect(input vec_t v);
    vec_t o = v;
    logic [AW-1:0]   ra [2];
    logic [AW-1:0]   wa [2];
    logic [XLEN-1:0] wd [2];
    logic [XLEN-1:0] d  [2];
    ra[0] = v.ra0; ra[1] = v.ra1; wa[0] = v.wa0; wa[1] = v.wa1; wd[0] = v.wd0; wd[1] = v.wd1;
    for (int i = 0; i < 2; i++) begin
      int hits = 0;
      int left;
      d[i] = m_mem[ra[i]];
      for (int k = 0; k < 2; k++) begin
        if (v.we[k] && wa[k] == ra[i]) begin
          d[i] = wd[k];
          hits++;
        end
      end
      left = m_cnt[ra[i]] - ((hits < m_cnt[ra[i]]) ? hits : m_cnt[ra[i]]);
      if (v.rst || !v.re[i] || ra[i] == 0) d[i] = '0;
      o.eb[i] = !v.rst && v.re[i] && (left != 0);
    end
    o.ed0 = d[0];
    o.ed1 = d[1];
    o.er  = !v.rst && (m_cnt[v.ia] != (1 << CNTW) - 1);
    return o;
  endfunction

  task automatic model_update(input vec_t v, input logic ready);
    logic [AW-1:0]   wa [2];
    logic [XLEN-1:0] wd [2];
    wa[0] = v.wa0; wa[1] = v.wa1; wd[0] = v.wd0; wd[1] = v.wd1;
    if (v.rst) begin
      for (int r = 0; r < NREG; r++) begin
        m_mem[r] = '0;
        m_cnt[r] = 0;
      end
      return;
    end
    for (int r = 1; r < NREG; r++) begin
      int hits = 0;
      for (int k = 0; k < 2; k++) if (v.we[k] && wa[k] == AW'(r)) hits++;
      if (v.fl) m_cnt[r] = 0;
      else m_cnt[r] = m_cnt[r] + ((v.iv && ready && v.ia == AW'(r)) ? 1 : 0)
                      - ((hits < m_cnt[r]) ? hits : m_cnt[r]);
    end
    for (int k = 0; k < 2; k++) if (v.we[k] && wa[k] != 0) m_mem[wa[k]] = wd[k];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);

    // reset clears a written register and masks outputs while asserted
    tbl.push_back(mk(0, 2'b11, 5, 6, 0, 0, 2'b01, 5, 32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 0, 2'b00, 1));
    tbl.push_back(mk(1, 2'b11, 5, 5, 1, 5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 5, 5, 0, 5, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    // same-cycle forwarding, then port priority
    tbl.push_back(mk(0, 2'b01, 7, 7, 0, 0, 2'b01, 7, 32'h1234, 0, 0, 0, 32'h1234, 0, 2'b00, 1));
    tbl.push_back(mk(0, 2'b11, 7, 7, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h1234, 32'h1234, 2'b00, 1));
    tbl.push_back(mk(0, 2'b11, 3, 7, 0, 0, 2'b11, 3, 32'hAAAA, 3, 32'h5555, 0, 32'h5555, 32'h1234, 2'b00, 1));
    tbl.push_back(mk(0, 2'b11, 3, 3, 0, 0, 2'b00, 0, 0, 0, 0, 0, 32'h5555, 32'h5555, 2'b00, 1));
    // saturate x9, retire one (stall not lifted that cycle), then retire two at once
    tbl.push_back(mk(0, 2'b01, 9, 0, 1, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    tbl.push_back(mk(0, 2'b01, 9, 0, 1, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b01, 9, 0, 1, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b01, 9, 0, 1, 9, 2'b01, 9, 32'h99, 0, 0, 0, 32'h99, 0, 2'b01, 0));
    tbl.push_back(mk(0, 2'b01, 9, 0, 0, 9, 2'b00, 0, 0, 0, 0, 0, 32'h99, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b01, 9, 0, 0, 9, 2'b11, 9, 32'hA1, 9, 32'hA2, 0, 32'hA2, 0, 2'b00, 1));
    tbl.push_back(mk(0, 2'b11, 9, 9, 0, 9, 2'b00, 0, 0, 0, 0, 0, 32'hA2, 32'hA2, 2'b00, 1));
    // x4: issue + write-back together keeps count at 1; write on empty count stays 0
    tbl.push_back(mk(0, 2'b10, 0, 4, 1, 4, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    tbl.push_back(mk(0, 2'b10, 0, 4, 1, 4, 2'b01, 4, 32'h44, 0, 0, 0, 0, 32'h44, 2'b00, 1));
    tbl.push_back(mk(0, 2'b10, 0, 4, 0, 4, 2'b00, 0, 0, 0, 0, 0, 0, 32'h44, 2'b10, 1));
    tbl.push_back(mk(0, 2'b10, 0, 4, 0, 4, 2'b01, 4, 32'h45, 0, 0, 0, 0, 32'h45, 2'b00, 1));
    tbl.push_back(mk(0, 2'b10, 0, 4, 0, 4, 2'b01, 4, 32'h46, 0, 0, 0, 0, 32'h46, 2'b00, 1));
    tbl.push_back(mk(0, 2'b10, 0, 4, 0, 4, 2'b00, 0, 0, 0, 0, 0, 0, 32'h46, 2'b00, 1));
    // x0 is hard-wired, then flush of two pending writes on x8
    tbl.push_back(mk(0, 2'b11, 0, 0, 1, 0, 2'b01, 0, 32'hFFFF, 0, 0, 0, 0, 0, 2'b00, 1));
    tbl.push_back(mk(0, 2'b11, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
    tbl.push_back(mk(0, 2'b01, 8, 0, 1, 8, 2'b10, 0, 0, 8, 32'h80, 0, 32'h80, 0, 2'b00, 1));
    tbl.push_back(mk(0, 2'b01, 8, 0, 1, 8, 2'b00, 0, 0, 0, 0, 0, 32'h80, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b01, 8, 0, 1, 8, 2'b00, 0, 0, 0, 0, 1, 32'h80, 0, 2'b01, 1));
    tbl.push_back(mk(0, 2'b01, 8, 0, 0, 8, 2'b00, 0, 0, 0, 0, 0, 32'h80, 0, 2'b00, 1));
    // flush together with reset behaves as reset
    tbl.push_back(mk(1, 2'b11, 8, 9, 1, 8, 2'b01, 8, 32'h77, 0, 0, 1, 0, 0, 2'b00, 0));
    tbl.push_back(mk(0, 2'b11, 8, 9, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      drive(tbl[i]);
      @(negedge clk);
      check_row(tbl[i], $sformatf("row%0d", i));
    end

    // Randomized run; the first cycle is a reset so the model starts in step.
    for (int n = 0; n < 500; n++) begin
      v.rst = (n == 0) || ($urandom_range(0, 63) == 0);
      v.re  = 2'($urandom);
      v.ra0 = AW'($urandom_range(0, 7));
      v.ra1 = AW'($urandom_range(0, 7));
      v.iv  = 1'($urandom);
      v.ia  = AW'($urandom_range(0, 7));
      v.we  = 2'($urandom) & 2'($urandom);
      v.wa0 = AW'($urandom_range(0, 7));
      v.wa1 = AW'($urandom_range(0, 7));
      v.wd0 = $urandom;
      v.wd1 = $urandom;
      v.fl  = ($urandom_range(0, 31) == 0);
      v = model_expect(v);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      check_row(v, $sformatf("rand%0d", n));
      model_update(v, v.er);
    end

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
